pc_fetch: RTL
=============

# pc_fetch

Fetch-stage program counter for the pipelined MIPS core. Holds the architectural PC, selects the next PC from sequential, branch/jump, exception-entry and eret sources, and drives the word address into the instruction memory in the same cycle. Flags instruction-fetch address errors (AdEL) and delay-slot status for the exception logic, and keeps a retired-fetch counter.

## Interface
- PC_RESET, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (4096 words).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC.
- npc_sel_D  in  2  0 = PC+4, 1 = branch, 2 = jump (j/jal), 3 = register jump (jr/jalr).
- br_taken_D  in  1  branch condition result; only meaningful when npc_sel_D = 1.
- br_off_D  in  32  sign-extended offset, already shifted left 2.
- j_index_D  in  26  instr_index field.
- rs_fwd_D  in  32  forwarded rs value for jr/jalr.
- pc_D  in  32  PC of the D-stage instruction (branch/jump base).
- exc_req  in  1  CP0 requests exception/interrupt entry.
- eret_req  in  1  eret committing; redirect to epc.
- epc  in  32  CP0 EPC.
- pc_F  out  32  current fetch address, to instruction memory.
- pc8_F  out  32  pc_F + 8, link value carried down the pipe.
- adel_F  out  1  fetch address misaligned or outside [IM_LO, IM_HI].
- exc_code_F  out  5  5'd4 when adel_F, else 5'd0.
- bd_F  out  1  F-stage instruction is a delay slot.
- fetch_cnt  out  32  count of PC advances since reset.

## Operation
- Next-PC priority, highest first: reset > exc_req > eret_req > stall > D-stage redirect > sequential.
- exc_req: PC ← HANDLER_PC, regardless of stall.
- eret_req, no exc_req: PC ← epc, regardless of stall.
- stall, no exc/eret: PC, bd_F, and fetch_cnt hold.
- Redirect targets:
  - branch: pc_D + 4 + br_off_D when br_taken_D, else pc_F + 4.
  - jump: {pc_D[31:28], j_index_D, 2'b00}.
  - register jump: rs_fwd_D.
- All arithmetic is 32-bit modulo; no overflow trap.
- adel_F is combinational from pc_F: pc_F[1:0] != 0, pc_F < IM_LO, or pc_F > IM_HI.
- An illegal PC is still presented on pc_F; the downstream F/D register replaces the instruction with nop using adel_F. The PC keeps advancing until exc_req.
- bd_F register:
  - set on an advance when npc_sel_D != 0, since a delay slot follows any branch/jump, taken or not.
  - cleared on any other advance, and on exc_req or eret_req.
- fetch_cnt increments on every non-stalled update, including exc/eret redirects; it wraps at 2^32.

## Timing
- Reset values: pc_F = 32'h3000, pc8_F = 32'h3008, adel_F = 0, exc_code_F = 0, bd_F = 0, fetch_cnt = 0.
- pc_F, bd_F, and fetch_cnt are registered and update on the clk edge.
- pc8_F, adel_F, and exc_code_F are combinational from pc_F.
- Instruction memory read is combinational, so the instruction is valid in the same cycle as pc_F. Redirect latency is one cycle, with no bubble beyond the architectural delay slot.
- exc_req and eret_req in the same cycle: exc_req wins.
- stall together with exc_req: the redirect still happens; the hazard unit flushes the D stage.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge.

## Structure
- Shared package `mips_defs` holds:
  - PC_RESET, HANDLER_PC, IM_LO, and IM_HI;
  - the NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings;
  - EXC_ADEL = 5'd4.
- One combinational sub-module, `npc_calc`, computes the branch, jump, and register targets. The priority mux and the registers live in pc_fetch.

## Test plan
- Reset, then 3 idle cycles -> pc_F = 3000, 3004, 3008, 300C; fetch_cnt = 3; bd_F = 0.
- beq at pc_D = 3004, br_off_D = 0x10, br_taken_D = 1 -> next pc_F = 0x3018 and bd_F = 1; with br_taken_D = 0 -> pc_F = 0x300C and bd_F = 1.
- jr with rs_fwd_D = 0x3002 -> pc_F = 0x3002, adel_F = 1, exc_code_F = 4. Then exc_req -> pc_F = 0x4180, bd_F = 0.
- stall held 3 cycles at pc_F = 0x3020 -> pc_F and fetch_cnt unchanged. exc_req during the stall -> pc_F = 0x4180 on the next edge.
- exc_req and eret_req together, epc = 0x3100 -> pc_F = 0x4180. eret_req alone -> pc_F = 0x3100.
- Sequential run from 0x6FF8 -> 0x6FFC (adel_F = 0), then 0x7000 (adel_F = 1). Reset asserted on the next edge -> pc_F = 0x3000, fetch_cnt = 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS core definitions: fetch address map, next-PC select encodings, exception codes.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package mips_defs;

    // Fetch address map
    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    // D-stage next-PC select encodings
    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // CP0 exception codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // A fetch address is legal when word aligned and inside the instruction memory window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Computes the D-stage redirect targets (branch, jump, register jump) from D-stage operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs are always valid for the current inputs.
//
// Ports:
//   pc_D       in  32  PC of the D-stage branch/jump
//   br_off_D   in  32  sign-extended, pre-shifted branch offset
//   j_index_D  in  26  instr_index field of j/jal
//   rs_fwd_D   in  32  forwarded rs value for jr/jalr
//   br_tgt     out 32  pc_D + 4 + br_off_D (modulo 2^32)
//   j_tgt      out 32  {pc_D[31:28], j_index_D, 2'b00}
//   jr_tgt     out 32  rs_fwd_D
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] pc_D,
    input  logic [31:0] br_off_D,
    input  logic [25:0] j_index_D,
    input  logic [31:0] rs_fwd_D,
    output logic [31:0] br_tgt,
    output logic [31:0] j_tgt,
    output logic [31:0] jr_tgt
);

    // Branch base is the delay-slot address (pc_D + 4); carries past bit 31 are dropped.
    assign br_tgt = pc_D + 32'd4 + br_off_D;

    // Jump stays within the 256 MB region of the branch instruction.
    assign j_tgt  = {pc_D[31:28], j_index_D, 2'b00};

    assign jr_tgt = rs_fwd_D;

endmodule

// File: rtl/pc_fetch.sv
// Fetch-stage PC: holds the architectural PC, picks the next PC, flags AdEL and delay-slot status.
// Latency: pc_F/bd_F/fetch_cnt update on the clock edge; pc8_F/adel_F/exc_code_F are combinational.
// Backpressure: stall holds PC, bd_F and fetch_cnt; exc_req and eret_req override stall.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   stall                 hazard unit hold request
//   npc_sel_D, br_taken_D, br_off_D, j_index_D, rs_fwd_D, pc_D   D-stage redirect inputs
//   exc_req, eret_req, epc                                      CP0 redirect inputs
//   pc_F, pc8_F           fetch address and link value
//   adel_F, exc_code_F    fetch address error flag and its exception code
//   bd_F                  F-stage instruction sits in a delay slot
//   fetch_cnt             PC advances since reset (wraps)
module pc_fetch
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel_D,
    input  logic        br_taken_D,
    input  logic [31:0] br_off_D,
    input  logic [25:0] j_index_D,
    input  logic [31:0] rs_fwd_D,
    input  logic [31:0] pc_D,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_F,
    output logic [31:0] pc8_F,
    output logic        adel_F,
    output logic [4:0]  exc_code_F,
    output logic        bd_F,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] pc_plus4;

    npc_calc u_npc_calc (
        .pc_D      (pc_D),
        .br_off_D  (br_off_D),
        .j_index_D (j_index_D),
        .rs_fwd_D  (rs_fwd_D),
        .br_tgt    (br_tgt),
        .j_tgt     (j_tgt),
        .jr_tgt    (jr_tgt)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Priority: exc_req > eret_req > stall > D-stage redirect > sequential.
    // Reset sits above all of these in the register block.
    always_comb begin
        pc_d  = pc_q;
        bd_d  = bd_q;
        cnt_d = cnt_q;
        if (exc_req) begin
            pc_d  = HANDLER_PC;
            bd_d  = 1'b0;
            cnt_d = cnt_q + 32'd1;
        end else if (eret_req) begin
            pc_d  = epc;
            bd_d  = 1'b0;
            cnt_d = cnt_q + 32'd1;
        end else if (!stall) begin
            cnt_d = cnt_q + 32'd1;
            // Any branch or jump in D, taken or not, means the next fetch is its delay slot.
            bd_d  = (npc_sel_D != NPC_SEQ);
            case (npc_sel_D)
                NPC_BR:  pc_d = br_taken_D ? br_tgt : pc_plus4;
                NPC_J:   pc_d = j_tgt;
                NPC_JR:  pc_d = jr_tgt;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            bd_q  <= 1'b0;
            cnt_q <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            bd_q  <= bd_d;
            cnt_q <= cnt_d;
        end
    end

    // An illegal PC is still presented; the F/D register turns it into a nop via adel_F.
    assign pc_F       = pc_q;
    assign pc8_F      = pc_q + 32'd8;
    assign adel_F     = fetch_addr_bad(pc_q);
    assign exc_code_F = adel_F ? EXC_ADEL : EXC_NONE;
    assign bd_F       = bd_q;
    assign fetch_cnt  = cnt_q;

endmodule
